// File: rtl/mult_pipe_if.sv
// Issue, branch-resolve and CDB signals of the pipelined multiplier FU.
// master = issue/CDB side, slave = the multiplier.
interface mult_pipe_if #(
  parameter int XLEN   = 32,
  parameter int BM_W   = 4,
  parameter int PREG_W = 6
);
  logic              in_valid;
  logic [1:0]        in_func;
  logic [XLEN-1:0]   in_src1;
  logic [XLEN-1:0]   in_src2;
  logic [PREG_W-1:0] in_dest;
  logic [BM_W-1:0]   in_bm;
  logic              in_ready;
  logic [BM_W-1:0]   b_mm_resolve;
  logic              b_mm_mispred;
  logic              cdb_en;
  logic              out_valid;
  logic [XLEN-1:0]   out_result;
  logic [PREG_W-1:0] out_dest;
  logic [BM_W-1:0]   out_bm;

  modport master (
    output in_valid, in_func, in_src1, in_src2, in_dest, in_bm,
    output b_mm_resolve, b_mm_mispred, cdb_en,
    input  in_ready, out_valid, out_result, out_dest, out_bm
  );

  modport slave (
    input  in_valid, in_func, in_src1, in_src2, in_dest, in_bm,
    input  b_mm_resolve, b_mm_mispred, cdb_en,
    output in_ready, out_valid, out_result, out_dest, out_bm
  );
endinterface

// File: rtl/mult_pipe.sv
// Stallable, squashable STAGES-deep RV32M/RV64M multiplier returning MUL/MULH/MULHSU/MULHU.
// Optional MULT_PIPE_SKID_EN adds an output skid entry so in_ready no longer depends on cdb_en.
module mult_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int BM_W   = 4,
  parameter int PREG_W = 6
) (
  input  logic       clock,
  input  logic       reset,
  mult_pipe_if.slave bus
);
  localparam int W2 = 2 * XLEN;
  localparam int SH = W2 / STAGES;
  localparam int L  = STAGES - 1;

  typedef enum logic [1:0] {
    FN_MUL    = 2'd0,
    FN_MULH   = 2'd1,
    FN_MULHSU = 2'd2,
    FN_MULHU  = 2'd3
  } func_e;

  logic              vld_q    [STAGES];
  logic [W2-1:0]     psum_q   [STAGES];
  logic [W2-1:0]     mplier_q [STAGES];
  logic [W2-1:0]     mcand_q  [STAGES];
  func_e             func_q   [STAGES];
  logic [PREG_W-1:0] dest_q   [STAGES];
  logic [BM_W-1:0]   bm_q     [STAGES];

  logic              vld_eff    [STAGES];
  logic [BM_W-1:0]   bm_eff     [STAGES];
  logic              ready      [STAGES];
  logic              src_vld    [STAGES];
  logic [W2-1:0]     src_psum   [STAGES];
  logic [W2-1:0]     src_mplier [STAGES];
  logic [W2-1:0]     src_mcand  [STAGES];
  func_e             src_func   [STAGES];
  logic [PREG_W-1:0] src_dest   [STAGES];
  logic [BM_W-1:0]   src_bm     [STAGES];
  logic [W2-1:0]     psum_d     [STAGES];
  logic [W2-1:0]     mplier_d   [STAGES];
  logic [W2-1:0]     mcand_d    [STAGES];

  func_e           in_fn;
  logic            last_go;
  logic [XLEN-1:0] res_last;

  // NOTE: every variable below is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    in_fn = func_e'(bus.in_func);
    // Stage 0 is fed by the issue port; operands are sign/zero-extended to 2*XLEN.
    src_vld[0]    = bus.in_valid & ~(bus.b_mm_mispred & |(bus.in_bm & bus.b_mm_resolve));
    src_psum[0]   = '0;
    src_mcand[0]  = {{XLEN{bus.in_src1[XLEN-1] & (in_fn != FN_MULHU)}}, bus.in_src1};
    src_mplier[0] = {{XLEN{bus.in_src2[XLEN-1] & ((in_fn == FN_MUL) || (in_fn == FN_MULH))}},
                     bus.in_src2};
    src_func[0]   = in_fn;
    src_dest[0]   = bus.in_dest;
    src_bm[0]     = bus.in_bm & ~bus.b_mm_resolve;

    for (int k = 0; k < STAGES; k++) begin
      vld_eff[k] = vld_q[k] & ~(bus.b_mm_mispred & |(bm_q[k] & bus.b_mm_resolve));
      bm_eff[k]  = bm_q[k] & ~bus.b_mm_resolve;
    end

    for (int k = 1; k < STAGES; k++) begin
      src_vld[k]    = vld_eff[k-1];
      src_psum[k]   = psum_q[k-1];
      src_mplier[k] = mplier_q[k-1];
      src_mcand[k]  = mcand_q[k-1];
      src_func[k]   = func_q[k-1];
      src_dest[k]   = dest_q[k-1];
      src_bm[k]     = bm_eff[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      psum_d[k]   = src_psum[k] + (W2'(src_mplier[k][SH-1:0]) * src_mcand[k]);
      mplier_d[k] = src_mplier[k] >> SH;
      mcand_d[k]  = src_mcand[k] << SH;
    end

    // A slot loads when it is empty or its occupant moves on; squashed slots count as empty.
    ready[L] = ~vld_eff[L] | last_go;
    for (int k = L - 1; k >= 0; k--) begin
      ready[k] = ~vld_eff[k] | ready[k+1];
    end

    res_last = (func_q[L] == FN_MUL) ? psum_q[L][XLEN-1:0] : psum_q[L][W2-1:XLEN];
  end

  assign bus.in_ready = ready[0];

  // NOTE: state uses non-blocking assignments; the data registers are reset too so out_* read 0 after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]    <= 1'b0;
        psum_q[k]   <= '0;
        mplier_q[k] <= '0;
        mcand_q[k]  <= '0;
        func_q[k]   <= FN_MUL;
        dest_q[k]   <= '0;
        bm_q[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= ready[k] ? src_vld[k] : vld_eff[k];
        if (ready[k] && src_vld[k]) begin
          psum_q[k]   <= psum_d[k];
          mplier_q[k] <= mplier_d[k];
          mcand_q[k]  <= mcand_d[k];
          func_q[k]   <= src_func[k];
          dest_q[k]   <= src_dest[k];
          bm_q[k]     <= src_bm[k];
        end else begin
          bm_q[k] <= bm_eff[k];
        end
      end
    end
  end

`ifdef MULT_PIPE_SKID_EN
  logic              skid_vld_q;
  logic [XLEN-1:0]   skid_res_q;
  logic [PREG_W-1:0] skid_dest_q;
  logic [BM_W-1:0]   skid_bm_q;
  logic              skid_vld_eff;
  logic [BM_W-1:0]   skid_bm_eff;

  assign skid_vld_eff = skid_vld_q & ~(bus.b_mm_mispred & |(skid_bm_q & bus.b_mm_resolve));
  assign skid_bm_eff  = skid_bm_q & ~bus.b_mm_resolve;
  // Last stage drains into the CDB or the skid whenever the skid is empty.
  assign last_go      = ~skid_vld_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      skid_vld_q  <= 1'b0;
      skid_res_q  <= '0;
      skid_dest_q <= '0;
      skid_bm_q   <= '0;
    end else if (skid_vld_q) begin
      skid_vld_q <= skid_vld_eff & ~bus.cdb_en;
      skid_bm_q  <= skid_bm_eff;
    end else if (vld_eff[L] && !bus.cdb_en) begin
      skid_vld_q  <= 1'b1;
      skid_res_q  <= res_last;
      skid_dest_q <= dest_q[L];
      skid_bm_q   <= bm_eff[L];
    end
  end

  assign bus.out_valid  = skid_vld_q ? skid_vld_eff : vld_eff[L];
  assign bus.out_result = skid_vld_q ? skid_res_q   : res_last;
  assign bus.out_dest   = skid_vld_q ? skid_dest_q  : dest_q[L];
  assign bus.out_bm     = skid_vld_q ? skid_bm_eff  : bm_eff[L];
`else
  assign last_go        = bus.cdb_en;
  assign bus.out_valid  = vld_eff[L];
  assign bus.out_result = res_last;
  assign bus.out_dest   = dest_q[L];
  assign bus.out_bm     = bm_eff[L];
`endif
endmodule
